ai_accel_task_responder: RTL and testbench

Slave-side endpoint of the AI accelerator bus. It terminates CPU register reads and writes and accepts task submissions from a core into a small in-order queue. It dispatches queued tasks one at a time to a compute engine and signals each completion back to the core. It sits between the core-facing accelerator interface (slave role) and a single compute engine.

---
 rtl/ai_accel_task_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_ai_accel_task_responder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_accel_task_responder.sv
// Accelerator bus slave: register file, status/count registers and an
// in-order task queue feeding a single compute engine.
module ai_accel_task_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    error,
    input  logic                    task_valid,
    input  logic [7:0]              task_id,
    input  logic [7:0]              task_type,
    output logic                    task_ready,
    output logic                    task_done,
    output logic                    eng_valid,
    output logic [7:0]              eng_id,
    output logic [7:0]              eng_type,
    input  logic                    eng_ready,
    input  logic                    eng_done
);
    localparam int BW   = DATA_WIDTH / 8;
    localparam int PW   = $clog2(QUEUE_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 6;

    typedef enum logic {A_IDLE, A_RESP} acc_state_e;
    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT} dsp_state_e;

    acc_state_e            acc_state_q, acc_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];

    dsp_state_e            dsp_state_q, dsp_state_d;
    logic [7:0]            q_id_q   [QUEUE_DEPTH];
    logic [7:0]            q_id_d   [QUEUE_DEPTH];
    logic [7:0]            q_type_q [QUEUE_DEPTH];
    logic [7:0]            q_type_d [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            fly_id_q, fly_id_d;
    logic [7:0]            last_id_q, last_id_d;
    logic [DATA_WIDTH-1:0] done_cnt_q, done_cnt_d;
    logic                  task_done_q, task_done_d;

    logic [2:0]            idx;
    logic                  addr_bad;
    logic                  acc_err;
    logic                  busy;
    logic                  can_accept;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign idx        = addr[5:3];
    assign addr_bad   = (addr[2:0] != 3'd0) || (addr[ADDR_WIDTH-1:6] != '0);
    assign acc_err    = addr_bad || (we && idx >= 3'd6);
    assign busy       = dsp_state_q != D_IDLE;
    assign can_accept = !rst && (count_q < CW'(QUEUE_DEPTH));
    assign push       = task_valid && can_accept;
    assign pop        = (dsp_state_q == D_ISSUE) && eng_ready;

    assign status_word = {{(DATA_WIDTH-24){1'b0}}, 8'(count_q), 7'd0,
                          busy, last_id_q};

    always_comb begin
        rd_word = '0;
        if (idx == 3'd6)
            rd_word = status_word;
        else if (idx == 3'd7)
            rd_word = done_cnt_q;
        else
            rd_word = regs_q[idx];
    end

    // Register access FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            acc_state_q <= A_IDLE;
        else
            acc_state_q <= acc_state_d;
    end

    // Register access FSM: next state, captured response, register writes
    always_comb begin
        acc_state_d = acc_state_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        regs_d      = regs_q;
        case (acc_state_q)
            A_IDLE: begin
                if (req) begin
                    acc_state_d = A_RESP;
                    error_d     = acc_err;
                    rdata_d     = (acc_err || we) ? '0 : rd_word;
                    if (we && !acc_err) begin
                        for (int i = 0; i < NREG; i++) begin
                            if (idx == 3'(i)) begin
                                for (int k = 0; k < BW; k++) begin
                                    if (be[k])
                                        regs_d[i][8*k +: 8] = wdata[8*k +: 8];
                                end
                            end
                        end
                    end
                end
            end
            default: acc_state_d = A_IDLE;
        endcase
    end

    // Register access FSM: outputs (pending response dropped under reset)
    always_comb begin
        ready = 1'b0;
        error = 1'b0;
        rdata = '0;
        if (acc_state_q == A_RESP && !rst) begin
            ready = 1'b1;
            error = error_q;
            rdata = rdata_q;
        end
    end

    // Dispatch FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            dsp_state_q <= D_IDLE;
        else
            dsp_state_q <= dsp_state_d;
    end

    // Dispatch FSM: next state plus queue bookkeeping
    always_comb begin
        dsp_state_d = dsp_state_q;
        q_id_d      = q_id_q;
        q_type_d    = q_type_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fly_id_d    = fly_id_q;
        last_id_d   = last_id_q;
        done_cnt_d  = done_cnt_q;
        task_done_d = 1'b0;
        if (push) begin
            q_id_d[wr_ptr_q]   = task_id;
            q_type_d[wr_ptr_q] = task_type;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        case (dsp_state_q)
            D_IDLE: begin
                if (count_q != '0)
                    dsp_state_d = D_ISSUE;
            end
            D_ISSUE: begin
                if (eng_ready) begin
                    dsp_state_d = D_WAIT;
                    fly_id_d    = q_id_q[rd_ptr_q];
                end
            end
            D_WAIT: begin
                if (eng_done) begin
                    dsp_state_d = D_IDLE;
                    last_id_d   = fly_id_q;
                    done_cnt_d  = done_cnt_q + DATA_WIDTH'(1);
                    task_done_d = 1'b1;
                end
            end
            default: dsp_state_d = D_IDLE;
        endcase
    end

    // Dispatch FSM: outputs
    always_comb begin
        task_ready = can_accept;
        task_done  = task_done_q && !rst;
        eng_valid  = (dsp_state_q == D_ISSUE) && !rst;
        eng_id     = 8'd0;
        eng_type   = 8'd0;
        if (eng_valid) begin
            eng_id   = q_id_q[rd_ptr_q];
            eng_type = q_type_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q     <= '0;
            error_q     <= 1'b0;
            regs_q      <= '{default: '0};
            q_id_q      <= '{default: '0};
            q_type_q    <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fly_id_q    <= '0;
            last_id_q   <= '0;
            done_cnt_q  <= '0;
            task_done_q <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            regs_q      <= regs_d;
            q_id_q      <= q_id_d;
            q_type_q    <= q_type_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fly_id_q    <= fly_id_d;
            last_id_q   <= last_id_d;
            done_cnt_q  <= done_cnt_d;
            task_done_q <= task_done_d;
        end
    end

endmodule

// File: tb/tb_ai_accel_task_responder.sv
// Bench for ai_accel_task_responder: register map, error handling,
// task queue, dispatch ordering and mid-operation reset.
module tb_ai_accel_task_responder;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int QD = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          req;
    logic          we;
    logic [7:0]    be;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          error;
    logic          task_valid;
    logic [7:0]    task_id;
    logic [7:0]    task_type;
    logic          task_ready;
    logic          task_done;
    logic          eng_valid;
    logic [7:0]    eng_id;
    logic [7:0]    eng_type;
    logic          eng_ready;
    logic          eng_done;

    ai_accel_task_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .req(req),
        .we(we), .be(be), .rdata(rdata), .ready(ready), .error(error),
        .task_valid(task_valid), .task_id(task_id), .task_type(task_type),
        .task_ready(task_ready), .task_done(task_done),
        .eng_valid(eng_valid), .eng_id(eng_id), .eng_type(eng_type),
        .eng_ready(eng_ready), .eng_done(eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] mregs [6];
    logic [15:0] mq [$];
    logic [15:0] pend [$];
    logic [63:0] m_done;
    logic [7:0]  m_last;
    bit          m_fly;
    logic [63:0] rd;

    function automatic logic [63:0] m_status();
        logic busy_m;
        busy_m = (mq.size() > 0) || m_fly;
        return {40'd0, 8'(mq.size()), 7'd0, busy_m, m_last};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++) mregs[i] = '0;
        mq.delete();
        pend.delete();
        m_done = '0;
        m_last = '0;
        m_fly  = 1'b0;
    endtask

    task automatic do_access(input logic w, input logic [31:0] a,
                             input logic [63:0] d, input logic [7:0] b,
                             input string nm, output logic [63:0] rd_o);
        logic [2:0]  i;
        logic        bad;
        logic [63:0] exp_rd;
        i   = a[5:3];
        bad = (a[2:0] != 0) || (a[31:6] != 0) || (w && i >= 3'd6);
        exp_rd = '0;
        if (!bad && !w)
            exp_rd = (i == 3'd6) ? m_status() : (i == 3'd7) ? m_done : mregs[i];
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early_ready got=%b want=0", nm, ready);
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1 || error !== bad || rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL %s resp got rdy=%b err=%b rdata=%h want rdy=1 err=%b rdata=%h",
                     nm, ready, error, rdata, bad, exp_rd);
        end
        rd_o = rdata;
        if (!bad && w) begin
            for (int k = 0; k < 8; k++)
                if (b[k]) mregs[i][8*k +: 8] = d[8*k +: 8];
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_len got=%b want=0", nm, ready);
        end
    endtask

    task automatic run_engine(input bit rnd, input int want, input int budget);
        int c, done_at, pulse_at, got;
        bit waiting, exp_tr;
        logic [15:0] cur;
        c = 0; done_at = -1; pulse_at = -1; got = 0; waiting = 0; cur = '0;
        while (got < want && c < budget) begin
            @(negedge clk);
            task_valid = (pend.size() > 0) && (!rnd || $urandom_range(0, 1) == 1);
            if (pend.size() > 0) {task_id, task_type} = pend[0];
            eng_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            eng_done  = waiting && (c == done_at);
            if (!waiting && rnd && $urandom_range(0, 7) == 0) eng_done = 1'b1;
            #1;
            exp_tr = mq.size() < QD;
            n_tests++;
            if (task_ready !== exp_tr) begin
                n_fail++;
                $display("FAIL eng_task_ready c=%0d got=%b want=%b", c, task_ready, exp_tr);
            end
            n_tests++;
            if (task_done !== (c == pulse_at)) begin
                n_fail++;
                $display("FAIL eng_task_done c=%0d got=%b want=%b", c, task_done, c == pulse_at);
            end
            if (c == pulse_at) begin
                got++;
                m_done++;
                m_last = cur[15:8];
                m_fly  = 1'b0;
            end
            if (waiting || c == pulse_at) begin
                n_tests++;
                if (eng_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL eng_one_in_flight c=%0d got=%b want=0", c, eng_valid);
                end
            end else if (eng_valid === 1'b1) begin
                n_tests++;
                if (mq.size() == 0 || {eng_id, eng_type} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL eng_head c=%0d got=%h want=%h (qsize %0d)",
                             c, {eng_id, eng_type}, (mq.size() > 0) ? mq[0] : 16'h0, mq.size());
                end
                if (eng_ready && mq.size() > 0) begin
                    cur     = mq.pop_front();
                    waiting = 1'b1;
                    m_fly   = 1'b1;
                    done_at = c + (rnd ? int'($urandom_range(1, 4)) : 3);
                end
            end
            if (waiting && c == done_at) begin
                waiting  = 1'b0;
                pulse_at = c + 1;
            end
            if (task_valid && task_ready && pend.size() > 0)
                mq.push_back(pend.pop_front());
            c++;
        end
        @(negedge clk);
        task_valid = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
        if (got < want) begin
            n_tests++;
            n_fail++;
            $display("FAIL eng_timeout got=%0d want=%0d completions", got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({task_ready, ready, error, eng_valid, task_done} !== 5'b0 ||
            eng_id !== 8'h0 || eng_type !== 8'h0 || rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got tr=%b rdy=%b err=%b ev=%b td=%b id=%h rd=%h want all 0",
                     task_ready, ready, error, eng_valid, task_done, eng_id, rdata);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (task_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_task_ready got=%b want=1", task_ready);
        end
        do_access(1'b0, 32'h30, '0, '0, "reset_status", rd);
        do_access(1'b0, 32'h38, '0, '0, "reset_done_cnt", rd);
    endtask

    task automatic test_byte_enables();
        logic [31:0] a;
        do_access(1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "be_full", rd);
        do_access(1'b1, 32'h10, 64'h1122_3344_5566_7788, 8'h0F, "be_low", rd);
        do_access(1'b0, 32'h10, '0, '0, "be_read", rd);
        n_tests++;
        if (rd !== 64'hFFFF_FFFF_5566_7788) begin
            n_fail++;
            $display("FAIL be_value got=%h want=ffffffff55667788", rd);
        end
        do_access(1'b1, 32'h10, 64'h0, 8'h00, "be_zero_write", rd);
        do_access(1'b0, 32'h10, '0, '0, "be_zero_read", rd);
        for (int n = 0; n < 30; n++) begin
            a = {26'd0, 3'($urandom_range(0, 7)), 3'd0};
            do_access(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                      8'($urandom), "rand_access", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] a;
        do_access(1'b1, 32'h30, 64'hDEAD_BEEF, 8'hFF, "err_wr_status", rd);
        do_access(1'b0, 32'h4, '0, '0, "err_misaligned", rd);
        do_access(1'b0, 32'h40, '0, '0, "err_high_addr", rd);
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            if (a[2:0] == 0 && a[31:6] == 0) a[0] = 1'b1;
            do_access(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                      8'hFF, "err_rand", rd);
        end
        for (int i = 0; i < 8; i++)
            do_access(1'b0, 32'(i * 8), '0, '0, "err_readback", rd);
    endtask

    task automatic test_queue_full();
        logic [7:0] id;
        logic       exp_tr;
        eng_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            id = 8'h10 + 8'(i);
            task_valid = 1'b1;
            task_id    = id;
            task_type  = 8'($urandom);
            #1;
            exp_tr = mq.size() < QD;
            n_tests++;
            if (task_ready !== exp_tr) begin
                n_fail++;
                $display("FAIL full_task_ready i=%0d got=%b want=%b", i, task_ready, exp_tr);
            end
            if (exp_tr) mq.push_back({task_id, task_type});
            else pend.push_back({task_id, task_type});
        end
        @(negedge clk);
        task_valid = 1'b0;
        #1;
        n_tests++;
        if (eng_valid !== 1'b1 || {eng_id, eng_type} !== mq[0]) begin
            n_fail++;
            $display("FAIL full_head got ev=%b %h want ev=1 %h", eng_valid, {eng_id, eng_type}, mq[0]);
        end
        do_access(1'b0, 32'h30, '0, '0, "full_status", rd);
    endtask

    task automatic test_engine_in_order();
        run_engine(1'b0, 5, 300);
        do_access(1'b0, 32'h38, '0, '0, "eng_done_cnt", rd);
        n_tests++;
        if (rd !== 64'd5) begin
            n_fail++;
            $display("FAIL eng_done_cnt5 got=%0d want=5", rd);
        end
        do_access(1'b0, 32'h30, '0, '0, "eng_status", rd);
        n_tests++;
        if (rd[7:0] !== 8'h14) begin
            n_fail++;
            $display("FAIL eng_last_id got=%h want=14", rd[7:0]);
        end
    endtask

    task automatic test_random_traffic();
        for (int n = 0; n < 12; n++)
            pend.push_back(16'($urandom));
        run_engine(1'b1, 12, 3000);
        do_access(1'b0, 32'h38, '0, '0, "rand_done_cnt", rd);
        do_access(1'b0, 32'h30, '0, '0, "rand_status", rd);
    endtask

    task automatic test_reset_mid();
        int k;
        eng_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            task_valid = 1'b1;
            task_id    = 8'h40 + 8'(i);
            task_type  = 8'($urandom);
            #1;
            n_tests++;
            if (task_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_accept i=%0d got=%b want=1", i, task_ready);
            end
            mq.push_back({task_id, task_type});
        end
        @(negedge clk);
        task_valid = 1'b0;
        k = 0;
        #1;
        while (eng_valid !== 1'b1 && k < 8) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (eng_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_issue got ev=%b want=1", eng_valid);
        end
        eng_ready = 1'b1;
        void'(mq.pop_front());
        m_fly = 1'b1;
        @(negedge clk);
        eng_ready = 1'b0;
        do_access(1'b0, 32'h30, '0, '0, "mid_status_wait", rd);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({ready, task_ready, eng_valid, task_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_rst_outputs got rdy=%b tr=%b ev=%b td=%b want 0000",
                     ready, task_ready, eng_valid, task_done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (task_ready !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release got tr=%b rdy=%b want tr=1 rdy=0", task_ready, ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            eng_done = (c == 1);
            #1;
            n_tests++;
            if ({task_done, eng_valid, ready} !== 3'b0) begin
                n_fail++;
                $display("FAIL mid_quiet c=%0d got td=%b ev=%b rdy=%b want 000",
                         c, task_done, eng_valid, ready);
            end
        end
        eng_done = 1'b0;
        do_access(1'b0, 32'h30, '0, '0, "mid_status_zero", rd);
        do_access(1'b0, 32'h38, '0, '0, "mid_done_zero", rd);
        do_access(1'b0, 32'h10, '0, '0, "mid_reg_zero", rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        task_valid = 1'b0; task_id = '0; task_type = '0;
        eng_ready = 1'b0; eng_done = 1'b0;
        test_reset();
        test_byte_enables();
        test_errors();
        test_queue_full();
        test_engine_in_order();
        test_random_traffic();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
